mips_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit owning the HI/LO registers of the MIPS core.

---
 rtl/mips_muldiv.sv | 73 +++++++
 tb/tb_mips_muldiv.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// mips_muldiv: multi-cycle MIPS multiply/divide unit owning the HI/LO registers
module mips_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  fncode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [31:0] up, lw, ob, abs_a, abs_b;
  logic is_div, neg_q, neg_r, go, is_md, sgn;
  logic [32:0] sum, rem, diff;
  logic [63:0] prod;
  assign go = start && state == IDLE;
  assign is_md = fncode[5:2] == 4'b0110;
  assign sgn = !fncode[0];
  assign busy = state != IDLE;
  assign abs_a = sgn && a[31] ? -a : a;
  assign abs_b = sgn && b[31] ? -b : b;
  assign sum = {1'b0, up} + (lw[0] ? {1'b0, ob} : 33'd0);
  assign rem = {up, lw[31]};
  assign diff = rem - {1'b0, ob};
  assign prod = {up, lw};
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: 32 RUN steps then one DONE cycle for the sign fixup and write-back
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (go && is_md ? RUN : IDLE) :
              state == RUN  ? (cnt == 5'd31 ? DONE : RUN) : IDLE;
  end
  // datapath: magnitudes iterate in {up,lw}; signs are restored only at DONE
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      up <= '0;
      lw <= '0;
      ob <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE) begin
      if (go && fncode == 6'h11) hi <= a;
      if (go && fncode == 6'h13) lo <= a;
      if (go && is_md) begin
        cnt <= '0;
        up <= '0;
        is_div <= fncode[1];
        lw <= fncode[1] ? abs_a : abs_b;
        ob <= fncode[1] ? abs_b : abs_a;
        neg_q <= sgn && (a[31] ^ b[31]) && b != 32'd0;
        neg_r <= sgn && a[31];
      end
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      up <= is_div ? (diff[32] ? rem[31:0] : diff[31:0]) : sum[32:1];
      lw <= is_div ? {lw[30:0], !diff[32]} : {sum[0], lw[31:1]};
    end else if (is_div) begin
      lo <= neg_q ? -lw : lw;
      hi <= neg_r ? -up : up;
    end else
      {hi, lo} <= neg_q ? -prod : prod;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed checks of mips_muldiv against a cycle-count/arithmetic model
module tb_mips_muldiv;
  logic clk = 1'b0, reset, start;
  logic [5:0] fncode;
  logic [31:0] a, b, hi, lo;
  logic busy;
  int checks = 0, errors = 0;
  int mcnt;
  logic [31:0] mhi, mlo;
  logic [63:0] pend;
  logic chk_en = 1'b0;

  mips_muldiv dut (.clk(clk), .reset(reset), .start(start), .fncode(fncode),
                   .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  // reference arithmetic returning {hi,lo}
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    if (f == 6'h19) res = {32'b0, x} * {32'b0, y};
    else if (f == 6'h18) res = sx * sy;
    else if (y == 32'd0) res = {x, 32'hFFFFFFFF};
    else if (f == 6'h1B) res = {x % y, x / y};
    else begin
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // model: result lands 33 edges after an accepted mul/div; busy while pending
  always @(posedge clk)
    if (reset) begin
      mcnt <= 0;
      mhi <= '0;
      mlo <= '0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) {mhi, mlo} <= pend;
    end else if (start) begin
      if (fncode == 6'h11) mhi <= a;
      if (fncode == 6'h13) mlo <= a;
      if (fncode >= 6'h18 && fncode <= 6'h1B) begin
        pend <= model(fncode, a, b);
        mcnt <= 33;
      end
    end

  // every-cycle comparison against the model
  always @(negedge clk)
    if (chk_en) begin
      checks++;
      if ({busy, hi, lo} !== {mcnt != 0, mhi, mlo}) begin
        errors++;
        $display("FAIL cycle t=%0t: busy/hi/lo=%b/%h/%h model=%b/%h/%h", $time, busy, hi, lo, mcnt != 0, mhi, mlo);
      end
    end

  task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op(input string nm, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                    input int exp_n, input logic [31:0] eh, input logic [31:0] el);
    int n;
    start = 1'b1;
    fncode = f;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      a = $urandom;
      b = $urandom;
      fncode = 6'($urandom);
      @(negedge clk);
    end
    lit({nm, " busy cycles"}, 64'(n), 64'(exp_n));
    lit({nm, " hi/lo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fncode = '0;
    a = '0;
    b = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    lit("reset state", {31'b0, busy, hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    op("multu max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001);
    op("mult -3*7", 6'h18, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op("divu 100/7", 6'h1B, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    op("divu by 0", 6'h1B, 32'h1234, 32'd0, 33, 32'h1234, 32'hFFFFFFFF);
    op("div min/-1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);
    op("mthi", 6'h11, 32'hAAAA5555, 32'd0, 0, 32'hAAAA5555, 32'h80000000);
    op("mflo noop", 6'h12, 32'h12345678, 32'd9, 0, 32'hAAAA5555, 32'h80000000);
    op("div 7/-2", 6'h1A, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
    op("mult min*min", 6'h18, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
    op("div -8/0", 6'h1A, 32'hFFFFFFF8, 32'd0, 33, 32'hFFFFFFF8, 32'hFFFFFFFF);
    op("divu max/1", 6'h1B, 32'hFFFFFFFF, 32'd1, 33, 32'd0, 32'hFFFFFFFF);
    op("mtlo", 6'h13, 32'h0000BEEF, 32'd0, 0, 32'd0, 32'h0000BEEF);
    start = 1'b1;
    fncode = 6'h19;
    a = 32'd3;
    b = 32'd5;
    @(negedge clk);
    repeat (4) @(negedge clk);
    fncode = 6'h13;
    a = 32'hDEAD0000;
    @(negedge clk);
    start = 1'b0;
    lit("mtlo while busy", {31'b0, busy, lo}, {31'b0, 1'b1, 32'h0000BEEF});
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    lit("multu 3*5 after ignored mtlo", {hi, lo}, {32'd0, 32'd15});
    start = 1'b1;
    fncode = 6'h18;
    a = 32'd5;
    b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lit("reset mid-op", {31'b0, busy, hi, lo}, 64'd0);
    op("multu after reset", 6'h19, 32'h10000, 32'h10000, 33, 32'd1, 32'd0);
    op("back-to-back div", 6'h1A, 32'hFFFFFF9C, 32'd7, 33, 32'hFFFFFFFE, 32'hFFFFFFF2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end
endmodule
